// File: rtl/dout_packer_pkg.sv
// Shared types and constants for the dout byte-to-word packer.
package dout_packer_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int MAX_PKT_LEN = 256;
  localparam int LANE_W      = $clog2(WORD_BYTES);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } obuf_entry_t;

  // Lanes 0..lane valid, in first-byte-is-lane-0 order.
  function automatic logic [3:0] keep_upto(input logic [LANE_W-1:0] lane);
    logic [3:0] k;
    case (lane)
      2'd0:    k = 4'b0001;
      2'd1:    k = 4'b0011;
      2'd2:    k = 4'b0111;
      default: k = 4'b1111;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/dout_packer_obuf.sv
// Small synchronous FIFO of packed words with registered full/empty flags.
module dout_packer_obuf
  import dout_packer_pkg::*;
#(
  parameter int OBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  obuf_entry_t push_entry,
  input  logic        pop,
  output obuf_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(OBUF_DEPTH);

  obuf_entry_t   mem_q [OBUF_DEPTH];
  obuf_entry_t   mem_d [OBUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (PW+1)'(OBUF_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Head is read straight from storage flops; stale when empty.
  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/dout_word_packer.sv
// Packs a length-framed byte stream into 32-bit words with keep/last marking.
// Build option DOUT_PACKER_BIG_ENDIAN_EN places the first byte in bits [31:24].
module dout_word_packer
  import dout_packer_pkg::*;
#(
  parameter int OBUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  len_value,
  input  logic        len_en,
  output logic        len_rdy,
  input  logic [7:0]  src_value,
  input  logic        src_rdy,
  output logic        src_en,
  output logic [31:0] word_value,
  output logic [3:0]  word_keep,
  output logic        word_last,
  output logic        word_rdy,
  input  logic        word_en,
  output logic [15:0] pkt_count,
  output state_t      dbg_state
);

  // Every method is enable/ready: an enable fires only in a cycle where the
  // matching ready is high; enables seen while ready is low have no effect.

  state_t              state_q, state_d;
  logic [8:0]          remaining_q, remaining_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [31:0]         hold_q, hold_d;
  logic [15:0]         pkt_count_q, pkt_count_d;
  logic [31:0]         word_le;
  logic [3:0]          keep_le;
  logic                last_byte;
  logic                push;
  obuf_entry_t         push_entry;
  obuf_entry_t         head;
  logic                obuf_full, obuf_empty;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    hold_d      = hold_q;
    pkt_count_d = pkt_count_q;
    len_rdy     = (state_q == IDLE);
    src_en      = 1'b0;
    push        = 1'b0;
    push_entry  = '0;
    last_byte   = (remaining_q == 9'd1);
    keep_le     = keep_upto(lane_q);
    word_le     = hold_q;
    word_le[{lane_q, 3'b000} +: 8] = src_value;

    case (state_q)
      IDLE: begin
        if (len_en) begin
          remaining_d = (len_value == 8'd0) ? 9'(MAX_PKT_LEN) : {1'b0, len_value};
          lane_d      = '0;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        src_en = src_rdy & ~obuf_full;
        if (src_en) begin
          lane_d      = lane_q + LANE_W'(1);
          remaining_d = remaining_q - 9'd1;
          if (lane_q == LANE_W'(WORD_BYTES - 1) || last_byte) begin
            push   = 1'b1;
            hold_d = '0;
`ifdef DOUT_PACKER_BIG_ENDIAN_EN
            push_entry.data = {word_le[7:0], word_le[15:8], word_le[23:16], word_le[31:24]};
            push_entry.keep = {keep_le[0], keep_le[1], keep_le[2], keep_le[3]};
`else
            push_entry.data = word_le;
            push_entry.keep = keep_le;
`endif
            push_entry.last = last_byte;
          end else begin
            hold_d = word_le;
          end
          if (last_byte) begin
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      lane_q      <= '0;
      hold_q      <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      hold_q      <= hold_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  dout_packer_obuf #(
    .OBUF_DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk        (CLK),
    .rst_n      (RST_N),
    .push       (push),
    .push_entry (push_entry),
    .pop        (word_en),
    .head       (head),
    .full       (obuf_full),
    .empty      (obuf_empty)
  );

  assign word_value = head.data;
  assign word_keep  = head.keep;
  assign word_last  = head.last;
  assign word_rdy   = ~obuf_empty;
  assign pkt_count  = pkt_count_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/dout_word_packer.md
# dout_word_packer

Downstream stage of the byte-stream interface block: it consumes that block's `dout` enable/ready method, packs bytes into 32-bit words, and marks packet boundaries. Each packet's byte length is programmed through a `len` action method before the packet is collected. Packed words are buffered in a small output FIFO and popped by the next stage through an actionvalue method.

## Interface
- `OBUF_DEPTH`, default 2: output FIFO depth in words; power of two, ≥2.
- `CLK`  in  1  sole clock; all state is updated on the rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `len_value`  in  8  packet length in bytes; 0 encodes 256.
- `len_en`  in  1  fires the `len` method; legal only while `len_rdy`=1.
- `len_rdy`  out  1  high in IDLE only.
- `src_value`  in  8  byte from upstream `dout_value`.
- `src_rdy`  in  1  upstream `dout_rdy`: a byte is available.
- `src_en`  out  1  drives upstream `dout_en`; a byte is consumed in every cycle where it is 1.
- `word_value`  out  32  packed word at the FIFO head.
- `word_keep`  out  4  valid-byte mask for `word_value`; bit i covers byte lane i.
- `word_last`  out  1  head word ends a packet.
- `word_rdy`  out  1  FIFO not empty.
- `word_en`  in  1  pops the head word; legal only while `word_rdy`=1.
- `pkt_count`  out  16  count of completed packets; wraps from 0xFFFF to 0.

## Operation
- States:
  - IDLE: `len_rdy`=1, `src_en`=0. When `len_en`=1, load `remaining` (9-bit) with `len_value`, or 256 if `len_value`=0. Clear `lane` to 0. Go to COLLECT.
  - COLLECT: `len_rdy`=0.
    - `src_en` = `src_rdy` AND NOT `obuf_full`. `obuf_full` is a registered flag; `word_en` has no combinational path to `src_en`.
    - On an accepted byte: write it into lane `lane` of the holding register, then increment `lane` mod 4 and decrement `remaining`.
    - A word is pushed in the same cycle as the accepted byte when `lane`=3 or `remaining`=1. The pushed word is the holding bytes plus the current byte.
    - `keep` for a pushed word is bits 0..`lane` set. Unused lanes are 0.
    - `last` = (`remaining`=1).
    - On the last byte: increment `pkt_count`, clear the holding register, return to IDLE.
- `len_en` asserted while `len_rdy`=0 is ignored. `word_en` asserted while `word_rdy`=0 is ignored.
- Simultaneous push and pop: allowed at any occupancy below full. At full, `src_en`=0, so no push can occur.
- Reset, asserted at any time including mid-packet:
  - state returns to IDLE; FIFO is emptied; any partial word is discarded.
  - `pkt_count`=0, `remaining`=0, `lane`=0.
- Output reset values: `len_rdy`=1, `src_en`=0, `word_rdy`=0, `word_value`=0, `word_keep`=0, `word_last`=0, `pkt_count`=0.

## Timing
- IDLE→COLLECT takes 1 cycle after `len_en`. `src_en` can first be high in the following cycle.
- Throughput: one byte per cycle while `src_rdy`=1 and the FIFO is not full.
- Latency: a word pushed in cycle N appears with `word_rdy`=1 in N+1 if the FIFO was empty. Otherwise it appears behind the older words.
- The last byte is accepted in cycle N; `len_rdy`=1 in N+1. There is no dead cycle between packets beyond the `len` handshake.
- FIFO head outputs (`word_value`, `word_keep`, `word_last`) are registered. When the FIFO is empty they show the last popped entry or reset zeros, and they are don't-care while `word_rdy`=0.
- `obuf_full` deasserts the cycle after a pop. `src_en` can therefore be low for one cycle after a pop from full.

## Configuration
- `DOUT_PACKER_BIG_ENDIAN_EN`:
  - Defined: the first byte of a word goes to bits [31:24]. Lane i maps to bits [31-8i:24-8i]. `word_keep` bit 3 marks the first byte.
  - Undefined (default): little-endian. The first byte goes to bits [7:0], and `word_keep` bit 0 marks the first byte.
  - Sequencing, `last`, and counts are identical in both builds.

## Structure
- Package `dout_packer_pkg`:
  - state enum {IDLE, COLLECT};
  - `WORD_BYTES`=4;
  - `MAX_PKT_LEN`=256;
  - a packed struct for a FIFO entry {data[31:0], keep[3:0], last}.
- Sub-module `dout_packer_obuf`: a synchronous FIFO of FIFO-entry structs.
  - Parameter `OBUF_DEPTH`; registered `full`/`empty`; a push and a pop in the same cycle are allowed.
  - Reset is shared with the parent.
- The top level holds the FSM, the lane and remaining counters, the holding register, and `pkt_count`.

## Test plan
- **Single-word packet, little-endian.** Program len=4, then bytes 11,22,33,44 back-to-back. Expect one word 0x44332211, keep=0xF, last=1, `pkt_count`=1, and `len_rdy`=1 in the cycle after byte 44 is accepted.
- **Partial final word.** Program len=6 with bytes 01..06. Expect word 0x04030201 keep=0xF last=0, then word 0x00000605 keep=0x3 last=1.
- **Length 256.** Program len_value=0 and stream 256 bytes. Expect 64 words, only the 64th with last=1, and `pkt_count` incremented by exactly 1.
- **Backpressure.** With `OBUF_DEPTH`=2, len=16, `word_en` held at 0: `src_en` falls after 8 bytes, and `word_rdy`=1 with 2 words stored. Release `word_en`: all 4 words arrive in order with none lost or duplicated.
- **Reset mid-packet.** Program len=10, accept 5 bytes, then pulse `RST_N` low asynchronously between clock edges. Expect all outputs at their reset values immediately. The next len=2 packet 0xAA,0xBB yields a single word 0x0000BBAA keep=0x3 last=1.
- **Big-endian build.** With `DOUT_PACKER_BIG_ENDIAN_EN` defined, len=3 with bytes 11,22,33. Expect word 0x11223300, keep=0xE, last=1.
